// File: rtl/seg7_pkg.sv
// Shared glyph table, code constants and FSM state encoding for the 7-segment scan decoder.
// Segment bit order is {a,b,c,d,e,f,g} with a in bit 6.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h7E;
    localparam logic [6:0] GLYPH_1     = 7'h30;
    localparam logic [6:0] GLYPH_2     = 7'h6D;
    localparam logic [6:0] GLYPH_3     = 7'h79;
    localparam logic [6:0] GLYPH_4     = 7'h33;
    localparam logic [6:0] GLYPH_5     = 7'h5B;
    localparam logic [6:0] GLYPH_6     = 7'h5F;
    localparam logic [6:0] GLYPH_7     = 7'h70;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h7B;
    localparam logic [6:0] GLYPH_ALT_6 = 7'h1F;
    localparam logic [6:0] GLYPH_ALT_7 = 7'h72;
    localparam logic [6:0] GLYPH_ALT_9 = 7'h73;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_ILLEGAL = 4'hE;

    typedef enum logic [1:0] {WAIT, SETTLE, CAPTURE, HOLD} seg7_state_e;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment glyph to BCD decoder with illegal-glyph flag.
// Alternate glyphs for 6, 7 and 9 are accepted only when SEG7_ALT_GLYPH_EN is defined.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] glyph,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        code    = CODE_ILLEGAL;
        illegal = 1'b1;
        case (glyph)
            GLYPH_0:     begin code = 4'd0;       illegal = 1'b0; end
            GLYPH_1:     begin code = 4'd1;       illegal = 1'b0; end
            GLYPH_2:     begin code = 4'd2;       illegal = 1'b0; end
            GLYPH_3:     begin code = 4'd3;       illegal = 1'b0; end
            GLYPH_4:     begin code = 4'd4;       illegal = 1'b0; end
            GLYPH_5:     begin code = 4'd5;       illegal = 1'b0; end
            GLYPH_6:     begin code = 4'd6;       illegal = 1'b0; end
            GLYPH_7:     begin code = 4'd7;       illegal = 1'b0; end
            GLYPH_8:     begin code = 4'd8;       illegal = 1'b0; end
            GLYPH_9:     begin code = 4'd9;       illegal = 1'b0; end
            GLYPH_BLANK: begin code = CODE_BLANK; illegal = 1'b0; end
`ifdef SEG7_ALT_GLYPH_EN
            GLYPH_ALT_6: begin code = 4'd6;       illegal = 1'b0; end
            GLYPH_ALT_7: begin code = 4'd7;       illegal = 1'b0; end
            GLYPH_ALT_9: begin code = 4'd9;       illegal = 1'b0; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-position BCD codes from a time-multiplexed 7-segment bus tap.
// Optional SEG7_ALT_GLYPH_EN (honoured by seg7_glyph_decode) accepts alternate 6/7/9 glyphs.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dsel,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_vld,
    output logic                    upd,
    output logic [2:0]              upd_idx,
    output logic                    frame_done,
    output logic                    err
);

    localparam logic [1:0] S_WAIT    = WAIT;
    localparam logic [1:0] S_SETTLE  = SETTLE;
    localparam logic [1:0] S_CAPTURE = CAPTURE;
    localparam logic [1:0] S_HOLD    = HOLD;
    localparam logic [7:0] STABLE_TARGET = 8'(STABLE_CYCLES);

    logic [1:0]                  state;
    logic [NUM_DIGITS-1:0]       smp_dsel;
    logic [6:0]                  smp_seg;
    logic [7:0]                  cnt;
    logic [7:0]                  cnt_next;
    logic [NUM_DIGITS-1:0][3:0]  digit_q;
    logic [NUM_DIGITS-1:0]       vld_q;
    logic [NUM_DIGITS-1:0]       frame_mask;
    logic [NUM_DIGITS-1:0]       cap_mask;
    logic                        upd_q;
    logic [2:0]                  upd_idx_q;
    logic                        frame_done_q;
    logic                        err_q;

    logic       dsel_onehot;
    logic       in_changed;
    logic       capture;
    logic [3:0] cap_code;
    logic       cap_illegal;
    logic [2:0] cap_idx;

    seg7_glyph_decode u_decode (
        .glyph   (smp_seg),
        .code    (cap_code),
        .illegal (cap_illegal)
    );

    assign dsel_onehot = is_onehot8(8'(dsel));
    assign in_changed  = (dsel != smp_dsel) || (seg != smp_seg);
    assign capture     = (state == S_CAPTURE);
    assign cap_mask    = capture ? smp_dsel : '0;
    assign cnt_next    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_comb begin
        cap_idx = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (smp_dsel[k]) cap_idx = 3'(k);
        end
    end

    // Stability qualifier: any input change restarts the count from the new sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAIT;
            smp_dsel <= '0;
            smp_seg  <= '0;
            cnt      <= 8'd0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (dsel_onehot) begin
                        smp_dsel <= dsel;
                        smp_seg  <= seg;
                        cnt      <= 8'd1;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!dsel_onehot) begin
                        state <= S_WAIT;
                    end else if (in_changed) begin
                        smp_dsel <= dsel;
                        smp_seg  <= seg;
                        cnt      <= 8'd1;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt_next >= STABLE_TARGET) state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: state <= S_HOLD;
                S_HOLD: begin
                    if (!dsel_onehot) begin
                        state <= S_WAIT;
                    end else if (in_changed) begin
                        smp_dsel <= dsel;
                        smp_seg  <= seg;
                        cnt      <= 8'd1;
                        state    <= S_SETTLE;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q   <= '1;
            vld_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
        end else begin
            upd_q <= capture;
            if (capture) begin
                upd_idx_q <= cap_idx;
                vld_q     <= vld_q | smp_dsel;
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (smp_dsel[k]) digit_q[k] <= cap_code;
                end
            end
        end
    end

    // A completed frame restarts the mask with whatever is captured in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_mask   <= '0;
            frame_done_q <= 1'b0;
        end else if (&frame_mask) begin
            frame_mask   <= cap_mask;
            frame_done_q <= 1'b1;
        end else begin
            frame_mask   <= frame_mask | cap_mask;
            frame_done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (capture && cap_illegal) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign digits     = digit_q;
    assign digit_vld  = vld_q;
    assign upd        = upd_q;
    assign upd_idx    = upd_idx_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// Expected captures are queued at stimulus time and checked on every upd pulse.
module tb_seg7_scan_decoder;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] code;
        logic       err;
    } exp_cap_t;

    typedef struct {
        logic [3:0] dsel;
        logic [6:0] seg;
        int         hold;
        logic [2:0] idx;
        logic [3:0] code;
        logic       err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dsel;
    logic        err_clr;
    logic [15:0] digits;
    logic [3:0]  digit_vld;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        frame_done;
    logic        err;

    exp_cap_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int fd_cnt = 0;
    int last_upd_cyc = 0;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .dsel       (dsel),
        .err_clr    (err_clr),
        .digits     (digits),
        .digit_vld  (digit_vld),
        .upd        (upd),
        .upd_idx    (upd_idx),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExpected(input logic [2:0] idx, input logic [3:0] code, input logic e);
        exp_cap_t x;
        x.idx  = idx;
        x.code = code;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Called at a negedge; drives the bus and lets it sit for the given number of clocks.
    task automatic applyStimulus(input logic [3:0] d, input logic [6:0] s, input int cycles);
        dsel = d;
        seg  = s;
        repeat (cycles) @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_cap_t e;
        #1;
        cyc++;
        if (rst_n && upd) begin
            upd_cnt++;
            last_upd_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_upd: got idx=%0d code=%0h, expected no capture",
                         upd_idx, digits[4*upd_idx +: 4]);
            end else begin
                e = exp_q.pop_front();
                checkOutput("upd_idx", 32'(upd_idx), 32'(e.idx));
                checkOutput("upd_code", 32'(digits[4*upd_idx +: 4]), 32'(e.code));
                checkOutput("upd_err", 32'(err), 32'(e.err));
            end
        end
        if (rst_n && frame_done) fd_cnt++;
    end

    vec_t vecs[4];

    initial begin
        int start_cyc;
        int upd_base;
        int fd_base;
        logic [3:0] alt9_code;
        logic       alt9_err;

        vecs[0] = '{dsel: 4'b0001, seg: 7'h30, hold: 6, idx: 3'd0, code: 4'd1, err: 1'b0};
        vecs[1] = '{dsel: 4'b0010, seg: 7'h6D, hold: 6, idx: 3'd1, code: 4'd2, err: 1'b0};
        vecs[2] = '{dsel: 4'b0100, seg: 7'h79, hold: 6, idx: 3'd2, code: 4'd3, err: 1'b0};
        vecs[3] = '{dsel: 4'b1000, seg: 7'h33, hold: 6, idx: 3'd3, code: 4'd4, err: 1'b0};

`ifdef SEG7_ALT_GLYPH_EN
        alt9_code = 4'd9;
        alt9_err  = 1'b0;
`else
        alt9_code = 4'hE;
        alt9_err  = 1'b1;
`endif

        rst_n   = 1'b0;
        dsel    = 4'b0000;
        seg     = 7'h00;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        checkOutput("reset_digits", 32'(digits), 32'hFFFF);
        checkOutput("reset_vld", 32'(digit_vld), 32'h0);
        checkOutput("reset_upd", 32'(upd), 32'h0);
        checkOutput("reset_upd_idx", 32'(upd_idx), 32'h0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);

        // First capture latency
        $display("[TB] first capture latency");
        pushExpected(3'd0, 4'd0, 1'b0);
        start_cyc = cyc;
        upd_base  = upd_cnt;
        applyStimulus(4'b0001, 7'h7E, 10);
        checkOutput("first_upd_cycle", 32'(last_upd_cyc - start_cyc), 32'd5);
        checkOutput("first_upd_count", 32'(upd_cnt - upd_base), 32'd1);
        checkOutput("first_digit0", 32'(digits[3:0]), 32'h0);
        checkOutput("first_vld", 32'(digit_vld), 32'b0001);
        checkOutput("first_err", 32'(err), 32'h0);

        $display("[TB] four-position scan");
        fd_base = fd_cnt;
        for (int i = 0; i < 4; i++) begin
            pushExpected(vecs[i].idx, vecs[i].code, vecs[i].err);
            applyStimulus(vecs[i].dsel, vecs[i].seg, vecs[i].hold);
        end
        applyStimulus(4'b1000, 7'h33, 2);
        checkOutput("scan_digits", 32'(digits), 32'h4321);
        checkOutput("scan_vld", 32'(digit_vld), 32'hF);
        checkOutput("scan_frame_done_count", 32'(fd_cnt - fd_base), 32'd1);

        $display("[TB] glitch rejection");
        pushExpected(3'd0, 4'd6, 1'b0);
        upd_base = upd_cnt;
        applyStimulus(4'b0001, 7'h5B, 2);
        applyStimulus(4'b0001, 7'h5F, 8);
        checkOutput("glitch_upd_count", 32'(upd_cnt - upd_base), 32'd1);
        checkOutput("glitch_digit0", 32'(digits[3:0]), 32'h6);

        $display("[TB] illegal glyph and err_clr");
        pushExpected(3'd2, 4'hE, 1'b1);
        applyStimulus(4'b0100, 7'h01, 6);
        applyStimulus(4'b0100, 7'h01, 4);
        checkOutput("illegal_digit2", 32'(digits[11:8]), 32'hE);
        checkOutput("illegal_err_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err_cleared", 32'(err), 32'h0);

        $display("[TB] non-one-hot select and blank glyph");
        upd_base = upd_cnt;
        applyStimulus(4'b0011, 7'h30, 20);
        checkOutput("multi_sel_no_upd", 32'(upd_cnt - upd_base), 32'd0);
        pushExpected(3'd1, 4'hF, 1'b0);
        applyStimulus(4'b0010, 7'h00, 6);
        checkOutput("blank_digit1", 32'(digits[7:4]), 32'hF);
        checkOutput("blank_err", 32'(err), 32'h0);

        $display("[TB] alternate nine glyph");
        pushExpected(3'd3, alt9_code, alt9_err);
        applyStimulus(4'b1000, 7'h73, 6);
        checkOutput("alt9_digit3", 32'(digits[15:12]), 32'(alt9_code));
        checkOutput("alt9_err", 32'(err), 32'(alt9_err));

        $display("[TB] reset during settle");
        upd_base = upd_cnt;
        applyStimulus(4'b0001, 7'h7E, 2);
        rst_n = 1'b0;
        dsel  = 4'b0000;
        #1;
        checkOutput("midrst_digits", 32'(digits), 32'hFFFF);
        checkOutput("midrst_vld", 32'(digit_vld), 32'h0);
        checkOutput("midrst_err", 32'(err), 32'h0);
        checkOutput("midrst_upd", 32'(upd), 32'h0);
        checkOutput("midrst_frame_done", 32'(frame_done), 32'h0);
        checkOutput("midrst_upd_idx", 32'(upd_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("midrst_no_upd", 32'(upd_cnt - upd_base), 32'd0);
        checkOutput("midrst_vld_after", 32'(digit_vld), 32'h0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the BCD-to-7-segment path.
- Samples a time-multiplexed 7-segment bus (segment lines plus one-hot digit select) and recovers one BCD code per digit position.
- Qualifies each digit for stability before capture.
- Flags illegal glyphs.
- Sits between a display-bus tap and self-check/readback logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- seg  in  7  segment lines, active-high lit; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g.
- dsel  in  NUM_DIGITS  one-hot digit select; bit k drives position k.
- err_clr  in  1  synchronous clear of the sticky err flag.
- digits  out  4*NUM_DIGITS  captured codes; position k occupies [4k+3:4k].
- digit_vld  out  NUM_DIGITS  bit k set once position k has been captured at least once.
- upd  out  1  one-cycle pulse on each capture.
- upd_idx  out  3  position index for the current upd pulse.
- frame_done  out  1  one-cycle pulse when every position has been captured since the last frame_done.
- err  out  1  sticky; set on an illegal glyph capture.

Behaviour:
- Reset (async): digits=all 4'hF, digit_vld=0, upd=0, upd_idx=0, frame_done=0, err=0, FSM=WAIT, counter=0, frame mask=0.
- Inputs are used directly; no synchronizers. The tap is synchronous to clk.
- Decode, applied to seg:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B give codes 0-9.
  - 00 (blank) gives 4'hF, legal.
  - Any other pattern gives 4'hE, illegal.
- FSM states:
  - WAIT: if dsel is not one-hot, stay in WAIT. Otherwise latch dsel and seg into the sample registers, counter=1, go to SETTLE.
  - SETTLE: if dsel or seg differs from the latched values, relatch, counter=1, stay in SETTLE. If dsel is not one-hot, go to WAIT. Otherwise counter++. When counter reaches STABLE_CYCLES, go to CAPTURE.
  - CAPTURE (one cycle): write the code into the selected position, set digit_vld[k], upd=1, upd_idx=k, set frame mask bit k. If the glyph is illegal, err=1. Go to HOLD.
  - HOLD: stay while dsel and seg are unchanged. On any change, go to SETTLE with the new values latched and counter=1. A non-one-hot dsel goes to WAIT.
- Latency: first sample cycle plus STABLE_CYCLES-1 settle cycles plus 1 capture cycle. upd is registered and asserts STABLE_CYCLES+1 cycles after the first stable sample.
- Segment change during HOLD on the same dsel: a new capture follows after the settle period. The digit value is overwritten.
- frame_done: asserted in the cycle after the frame mask becomes all-ones. The mask clears in the same cycle. A capture in that cycle sets its bit into the new frame.
- err_clr and an illegal capture in the same cycle: set wins.
- Counter saturates; it never wraps.
- Reset mid-settle discards the partial sample with no upd.

Optional Feature:
- Macro: SEG7_ALT_GLYPH_EN.
- Defined: additionally accept the alternate glyphs 6=1F (no top bar), 7=72 (with f), 9=73 (no bottom bar) as legal codes 6, 7 and 9.
- Undefined: those patterns are illegal, giving code 4'hE and setting err.

Decomposition:
- Package seg7_pkg holds:
  - the ten standard glyph constants, the three alternate glyphs, and the blank glyph;
  - code constants BLANK=4'hF and ILLEGAL=4'hE;
  - FSM state enum {WAIT, SETTLE, CAPTURE, HOLD}.
- Sub-module seg7_glyph_decode: purely combinational, 7-bit glyph in, 4-bit code plus illegal flag out. It also honours the macro.
- Top level holds the FSM, counter, sample registers, capture registers and frame logic.

Test Plan:
- Reset, then sweep dsel=0001, seg=7E held 10 cycles → upd pulse with upd_idx=0 on cycle 5, digits[3:0]=0, digit_vld=0001, err=0.
- Scan 4 positions with glyphs 30, 6D, 79, 33, each held 6 cycles → digits=16'h4321, frame_done pulses once after the 4th capture.
- Glitch: seg=5B for 2 cycles, then 5F held → no capture of 5; capture code 6 after STABLE_CYCLES of 5F.
- Illegal glyph 0x01 held on position 2 → digits[11:8]=E, err=1 and sticky. err_clr asserted with no new illegal glyph → err=0.
- dsel=0011 (not one-hot) held 20 cycles → no upd, state WAIT. Blank glyph 00 on position 1 → code F, legal.
- Glyph 73 on position 3, run with and without SEG7_ALT_GLYPH_EN → 9 with no err (defined); E with err=1 (undefined). Assert rst_n mid-SETTLE → no upd, all outputs return to reset values.
